// File: rtl/obuf_drain_ctrl.sv
// obuf_drain_ctrl
//   Read-side sequencer for the systolic output buffer. A start pulse walks a
//   contiguous row range of the per-column output RAMs, one read per row.
//   Each returning column accumulator is requantized to a signed activation.
//   Packed rows are then streamed downstream over valid/ready. A 2-entry FIFO
//   plus an in-flight read flag absorbs the one-cycle RAM read latency.
//
//   Optional feature macro: OBUF_DRAIN_RELU_EN
//     When defined, a fused ReLU follows saturation (range 0..127).
//     When undefined, the output is pure signed saturation (range -128..127).
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          job start pulse, accepted only while idle
//   base_addr      first row address (latched on start)
//   num_rows       rows to drain (latched on start)
//   num_cols       valid columns; higher columns read as zero (latched on start)
//   busy, done     job status, one-cycle done pulse
//   rd_en/rd_addr  output-RAM read request, address shared by all columns
//   rd_data        column m at [OUT_WIDTH*m +: OUT_WIDTH], one cycle after rd_en
//   act_valid/act_ready/act_data/act_last  downstream activation stream
module obuf_drain_ctrl #(
  parameter int ARRAY_M    = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int ACT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH:0]           num_rows,
  input  logic [$clog2(ARRAY_M):0]      num_cols,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [ARRAY_M*OUT_WIDTH-1:0]  rd_data,
  output logic                          act_valid,
  input  logic                          act_ready,
  output logic [ARRAY_M*ACT_WIDTH-1:0]  act_data,
  output logic                          act_last
);

  localparam int COL_W = $clog2(ARRAY_M) + 1;
  localparam int ROW_W = ADDR_WIDTH + 1;
  localparam int ENT_W = ARRAY_M * ACT_WIDTH + 1;

  localparam logic signed [OUT_WIDTH-1:0] ACT_MAX = OUT_WIDTH'((1 << (ACT_WIDTH - 1)) - 1);
  localparam logic signed [OUT_WIDTH-1:0] ACT_MIN = ~ACT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state;
  logic [ADDR_WIDTH-1:0]       base_q;
  logic [ROW_W-1:0]            rows_q;
  logic [ROW_W-1:0]            issued_q;
  logic [COL_W-1:0]            cols_q;

  logic                        vld_p1;
  logic                        last_p1;
  logic [ARRAY_M*ACT_WIDTH-1:0] act_p1;

  logic [ENT_W-1:0]            fifo_mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  fifo_count;

  logic                        push;
  logic                        pop;
  logic [2:0]                  slots;
  logic                        last_issue;

  function automatic logic signed [ACT_WIDTH-1:0] sat_act(
    input logic signed [OUT_WIDTH-1:0] x
  );
    if (x > ACT_MAX)
      return ACT_MAX[ACT_WIDTH-1:0];
    else if (x < ACT_MIN)
      return ACT_MIN[ACT_WIDTH-1:0];
    else
      return x[ACT_WIDTH-1:0];
  endfunction

  function automatic logic signed [ACT_WIDTH-1:0] relu_act(
    input logic signed [ACT_WIDTH-1:0] a
  );
`ifdef OBUF_DRAIN_RELU_EN
    return a[ACT_WIDTH-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  function automatic logic [ARRAY_M*ACT_WIDTH-1:0] requant_row(
    input logic [ARRAY_M*OUT_WIDTH-1:0] raw,
    input logic [COL_W-1:0]             cols
  );
    logic [ARRAY_M*ACT_WIDTH-1:0] row;
    row = '0;
    for (int m = 0; m < ARRAY_M; m++) begin
      if (COL_W'(m) < cols)
        row[ACT_WIDTH*m +: ACT_WIDTH] = relu_act(sat_act(raw[OUT_WIDTH*m +: OUT_WIDTH]));
    end
    return row;
  endfunction

  // Stage p0: read issue. The slot budget counts buffered rows plus the read
  // still in flight, credited by a pop happening this same cycle, so rd_en
  // falls combinationally the moment a new read could not be absorbed.
  assign pop        = act_valid & act_ready;
  assign slots      = 3'(fifo_count) + 3'(vld_p1);
  assign rd_en      = (state == RUN) && (slots < (3'd2 + 3'(pop)));
  assign rd_addr    = base_q + issued_q[ADDR_WIDTH-1:0];
  assign last_issue = (issued_q == (rows_q - ROW_W'(1)));
  assign busy       = (state != IDLE);

  // Stage p1: RAM data returns; requantize on the way into the FIFO.
  assign push   = vld_p1;
  assign act_p1 = requant_row(rd_data, cols_q);

  // Stage p2: FIFO head drives the stream; contents are only shown while valid.
  assign act_valid             = (fifo_count != 2'd0);
  assign {act_last, act_data}  = act_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      base_q     <= '0;
      rows_q     <= '0;
      issued_q   <= '0;
      cols_q     <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      done    <= (state == DONE);
      vld_p1  <= rd_en;
      last_p1 <= rd_en & last_issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(push) - 2'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            rows_q   <= num_rows;
            cols_q   <= num_cols;
            issued_q <= '0;
            state    <= (num_rows == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_en) begin
            issued_q <= issued_q + ROW_W'(1);
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once the FIFO empties this cycle and nothing is returning.
          if (!vld_p1 && (fifo_count == 2'(pop))) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {last_p1, act_p1};
  end

endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// Bench for obuf_drain_ctrl: behavioural output RAM, scoreboard of expected
// read addresses and activation rows filled at job start, checked at negedge.
module tb_obuf_drain_ctrl;

  localparam int M  = 8;
  localparam int OW = 32;
  localparam int AW = 8;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DW-1:0]     base_addr;
  logic [DW:0]       num_rows;
  logic [3:0]        num_cols;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [DW-1:0]     rd_addr;
  logic [M*OW-1:0]   rd_data = '0;
  logic              act_valid;
  logic              act_ready;
  logic [M*AW-1:0]   act_data;
  logic              act_last;

  int ram [256][M];
  int n_chk = 0;
  int n_bad = 0;
  logic [M*AW:0] sb_q [$];
  logic [DW-1:0] addr_q [$];
  bit mon_on = 0;
  int n_rd = 0;
  int n_beat = 0;
  bit prev_stall = 0;
  logic [M*AW:0] prev_beat = '0;

  obuf_drain_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .num_cols(num_cols), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .act_last(act_last)
  );

  always #5 clk = ~clk;

  // Output RAM: one cycle read latency.
  always @(posedge clk) begin
    if (rd_en)
      for (int m = 0; m < M; m++) rd_data[m*OW +: OW] <= ram[rd_addr][m];
  end

  task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_act(input int x, input int m, input int cols);
    int y;
    if (m >= cols) return 0;
    if (x > 127) y = 127;
    else if (x < -128) y = -128;
    else y = x;
`ifdef OBUF_DRAIN_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      bit beat;
      logic [M*AW:0] exp_beat;
      beat = act_valid && act_ready;
      if (prev_stall) begin
        check_val("stall_valid", act_valid, 1'b1);
        check_val("stall_hold", {act_last, act_data}, prev_beat);
      end
      if (rd_en) begin
        if (addr_q.size() == 0) check_val("extra_read", 1'b1, 1'b0);
        else check_val("rd_addr", rd_addr, addr_q.pop_front());
        check_val("outstanding", ((n_rd + 1 - n_beat - int'(beat)) <= 2), 1'b1);
      end
      if (beat) begin
        if (sb_q.size() == 0) check_val("extra_beat", 1'b1, 1'b0);
        else begin
          exp_beat = sb_q.pop_front();
          check_val("act_row", {act_last, act_data}, exp_beat);
        end
      end
      if (rd_en) n_rd++;
      if (beat) n_beat++;
      prev_stall = act_valid && !act_ready;
      prev_beat  = {act_last, act_data};
    end
  end

  // mode 0: act_ready held high; mode 1: repeating 1,0,0,1,0,1 pattern.
  task automatic run_job(input int base, input int n, input int cols, input int mode,
                         input int exp_done, input bit second_start);
    int pat [6];
    int cyc;
    int done_cyc;
    bit got_done;
    logic [M*AW:0] row;
    pat = '{1, 0, 0, 1, 0, 1};
    @(posedge clk); #1;
    base_addr = DW'(base);
    num_rows  = 9'(n);
    num_cols  = 4'(cols);
    start     = 1'b1;
    act_ready = (mode == 0) ? 1'b1 : 1'(pat[0]);
    for (int r = 0; r < n; r++) begin
      int a;
      a = (base + r) & 255;
      addr_q.push_back(DW'(a));
      row = '0;
      for (int m = 0; m < M; m++) row[m*AW +: AW] = AW'(exp_act(ram[a][m], m, cols));
      row[M*AW] = (r == n - 1);
      sb_q.push_back(row);
    end
    cyc = 0; done_cyc = -1; got_done = 0;
    while (!got_done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start = second_start && (cyc == 1);
      if (second_start && cyc == 1) num_rows = 9'd4;
      act_ready = (mode == 0) ? 1'b1 : 1'(pat[cyc % 6]);
      @(negedge clk);
      if (cyc == 1) check_val("busy", busy, 1'b1);
      if (done) begin got_done = 1; done_cyc = cyc; end
    end
    check_val("done_seen", got_done, 1'b1);
    if (exp_done >= 0) check_val("done_cycle", done_cyc, exp_done);
    check_val("sb_left", sb_q.size(), 0);
    check_val("addr_left", addr_q.size(), 0);
    @(posedge clk); #1; act_ready = 1'b1;
    @(negedge clk);
    check_val("done_pulse", done, 1'b0);
    check_val("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int vals [4];
    vals = '{5, 200, -300, -7};
    reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0;
    act_ready = 1'b0;
    for (int a = 0; a < 256; a++)
      for (int m = 0; m < M; m++) ram[a][m] = int'($urandom_range(0, 1200)) - 600;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_rd_en", rd_en, 1'b0);
    check_val("rst_rd_addr", rd_addr, 8'h00);
    check_val("rst_valid", act_valid, 1'b0);
    check_val("rst_data", act_data, 64'h0);
    check_val("rst_last", act_last, 1'b0);
    @(posedge clk); #1; reset = 1'b0;
    mon_on = 1;

    // saturation corners, full width
    for (int r = 0; r < 4; r++)
      for (int m = 0; m < M; m++) ram[16 + r][m] = vals[r];
    run_job(16, 4, 8, 0, 8, 0);

    // partial column mask
    for (int r = 0; r < 4; r++)
      for (int m = 0; m < M; m++) ram[48 + r][m] = 32'h11;
    run_job(48, 4, 3, 0, 8, 0);

    // address wrap
    run_job(254, 4, 8, 0, 8, 0);

    // backpressure over 16 rows
    run_job(128, 16, 8, 1, -1, 0);

    // empty job, with a start while busy that must be ignored
    run_job(0, 0, 8, 0, 2, 1);
    repeat (4) @(posedge clk);

    // reset mid-job with both FIFO slots occupied
    mon_on = 0;
    @(posedge clk); #1;
    base_addr = 8'h20; num_rows = 9'd8; num_cols = 4'd8; start = 1'b1; act_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_valid", act_valid, 1'b1);
    check_val("pre_rst_busy", busy, 1'b1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_valid", act_valid, 1'b0);
    check_val("mid_rst_rd_en", rd_en, 1'b0);
    check_val("mid_rst_data", act_data, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_done_after_rst", done, 1'b0);
    end
    sb_q.delete();
    addr_q.delete();
    mon_on = 1;
    run_job(64, 5, 8, 0, 9, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
